// File: rtl/fp_pkg.sv
// Shared widths, FSM state type and operand-decode helpers for the FP operand aligner.
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int FRAC_W    = 23;
  localparam int MAN_W     = 27;
  localparam int MAX_SHIFT = 27;
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Denormals (exp == 0) behave as exponent 1 when measuring the alignment distance.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == {EXP_W{1'b0}}) ? {{(EXP_W-1){1'b0}}, 1'b1} : e;
  endfunction

  function automatic logic [MAN_W-1:0] make_man(input logic [EXP_W-1:0] e,
                                                input logic [FRAC_W-1:0] f);
    return {(e != {EXP_W{1'b0}}), f, 3'b000};
  endfunction

endpackage

// File: rtl/fp_sticky_shift.sv
// Right shift of an aligned mantissa by a small amount, folding every dropped bit into the sticky LSB.
module fp_sticky_shift
  import fp_pkg::*;
(
  input  logic [MAN_W-1:0] man_i,
  input  logic [CNT_W-1:0] amt_i,
  output logic [MAN_W-1:0] man_o
);

  logic [MAN_W-1:0] shifted_s;
  logic [MAN_W-1:0] mask_s;
  logic             sticky_s;

  // The mask covers the bits leaving the word, which includes the previous sticky bit.
  always_comb begin
    shifted_s = man_i >> amt_i;
    mask_s    = ~({MAN_W{1'b1}} << amt_i);
    sticky_s  = |(man_i & mask_s);
    man_o     = {shifted_s[MAN_W-1:1], shifted_s[0] | sticky_s};
  end

endmodule

// File: rtl/fp_align.sv
// Exponent-alignment front end of an FP adder: picks the larger operand and shifts the smaller mantissa.
module fp_align
  import fp_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       num1,
  input  logic [31:0]       num2,
  input  logic              sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MAN_W-1:0]  man_big,
  output logic [MAN_W-1:0]  man_small,
  output logic [EXP_W-1:0]  exp_out,
  output logic              eff_sub,
  output logic              swap,
  output logic              special
);

  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

  state_e             state_q, state_d;
  logic [MAN_W-1:0]   man_big_q, man_big_d, man_small_q, man_small_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               eff_sub_q, eff_sub_d, swap_q, swap_d, special_q, special_d;
  logic               in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [EXP_W-1:0]   e1_s, e2_s, d_s;
  logic [FRAC_W-1:0]  f1_s, f2_s;
  logic               swap_s, spec_s;
  logic [CNT_W-1:0]   cnt_init_s, amt_s;
  logic [MAN_W-1:0]   shifted_s;

  assign e1_s = num1[30:23];
  assign e2_s = num2[30:23];
  assign f1_s = num1[22:0];
  assign f2_s = num2[22:0];

  fp_sticky_shift u_shift (
    .man_i (man_small_q),
    .amt_i (amt_s),
    .man_o (shifted_s)
  );

  // Operand decode at capture time; ties keep num1 as the larger operand.
  always_comb begin
    swap_s     = {e2_s, f2_s} > {e1_s, f1_s};
    spec_s     = (e1_s == 8'hFF) || (e2_s == 8'hFF);
    d_s        = swap_s ? (eff_exp(e2_s) - eff_exp(e1_s)) : (eff_exp(e1_s) - eff_exp(e2_s));
    cnt_init_s = (d_s > 8'(MAX_SHIFT)) ? 5'(MAX_SHIFT) : d_s[CNT_W-1:0];
    amt_s      = (cnt_q < STEP_C) ? cnt_q : STEP_C;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    man_big_d   = man_big_q;
    man_small_d = man_small_q;
    exp_d       = exp_q;
    cnt_d       = cnt_q;
    eff_sub_d   = eff_sub_q;
    swap_d      = swap_q;
    special_d   = special_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          swap_d      = swap_s;
          special_d   = spec_s;
          eff_sub_d   = sel ^ num1[31] ^ num2[31];
          man_big_d   = swap_s ? make_man(e2_s, f2_s) : make_man(e1_s, f1_s);
          man_small_d = swap_s ? make_man(e1_s, f1_s) : make_man(e2_s, f2_s);
          exp_d       = swap_s ? e2_s : e1_s;
          cnt_d       = spec_s ? 5'd0 : cnt_init_s;
          state_d     = (spec_s || (cnt_init_s == 5'd0)) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        man_small_d = shifted_s;
        cnt_d       = cnt_q - amt_s;
        if (cnt_d == 5'd0) begin
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers; handshake flags stay low through reset.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q     <= IDLE;
      man_big_q   <= {MAN_W{1'b0}};
      man_small_q <= {MAN_W{1'b0}};
      exp_q       <= {EXP_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      eff_sub_q   <= 1'b0;
      swap_q      <= 1'b0;
      special_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      man_big_q   <= man_big_d;
      man_small_q <= man_small_d;
      exp_q       <= exp_d;
      cnt_q       <= cnt_d;
      eff_sub_q   <= eff_sub_d;
      swap_q      <= swap_d;
      special_q   <= special_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign man_big   = man_big_q;
  assign man_small = man_small_q;
  assign exp_out   = exp_q;
  assign eff_sub   = eff_sub_q;
  assign swap      = swap_q;
  assign special   = special_q;

endmodule

// File: tb/tb_fp_align.sv
// Directed bench for fp_align: one STEP=1 instance for most vectors, one STEP=4 instance for the latency case.
module tb_fp_align;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] num1, num2;
  logic        sel;
  logic [26:0] man_big, man_small;
  logic [7:0]  exp_out;
  logic        eff_sub, swap, special;

  logic        in_valid4, in_ready4, out_valid4, out_ready4;
  logic [26:0] man_big4, man_small4;
  logic [7:0]  exp_out4;
  logic        eff_sub4, swap4, special4;

  int n_checks = 0;
  int n_fail   = 0;
  int edges;

  always #5 clk = ~clk;

  fp_align #(.STEP(1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .num1(num1), .num2(num2), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .man_big(man_big), .man_small(man_small), .exp_out(exp_out),
    .eff_sub(eff_sub), .swap(swap), .special(special)
  );

  fp_align #(.STEP(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4),
    .num1(num1), .num2(num2), .sel(sel), .out_valid(out_valid4), .out_ready(out_ready4),
    .man_big(man_big4), .man_small(man_small4), .exp_out(exp_out4),
    .eff_sub(eff_sub4), .swap(swap4), .special(special4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair; edges counts from the accepting edge (= 1) to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int n);
    check("ready_before_op", 32'(in_ready), 32'd1);
    num1 = a; num2 = b; sel = s; in_valid = 1'b1;
    tick();
    n = 1;
    in_valid = 1'b0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_valid", 32'(out_valid), 32'd0);
    check("pop_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num1 = 32'd0; num2 = 32'd0; sel = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_man_big", 32'(man_big), 32'd0);
    check("rst_exp", 32'(exp_out), 32'd0);
    rstn = 1'b0;
    tick();
    check("rel_ready", 32'(in_ready), 32'd1);

    // 1.0 + 1.0: no alignment needed
    run_op(32'h3F800000, 32'h3F800000, 1'b0, edges);
    check("eq_lat", 32'(edges), 32'd1);
    check("eq_big", 32'(man_big), 32'h4000000);
    check("eq_small", 32'(man_small), 32'h4000000);
    check("eq_exp", 32'(exp_out), 32'h7F);
    check("eq_effsub", 32'(eff_sub), 32'd0);
    check("eq_swap", 32'(swap), 32'd0);
    pop();

    // 2.0 - 1.0: one shift
    run_op(32'h40000000, 32'h3F800000, 1'b1, edges);
    check("d1_lat", 32'(edges), 32'd2);
    check("d1_small", 32'(man_small), 32'h2000000);
    check("d1_exp", 32'(exp_out), 32'h80);
    check("d1_effsub", 32'(eff_sub), 32'd1);
    check("d1_swap", 32'(swap), 32'd0);
    pop();

    // d = 25 with num2 larger, STEP = 1
    run_op(32'h3F800000, 32'h4C000000, 1'b0, edges);
    check("d25_lat", 32'(edges), 32'd26);
    check("d25_swap", 32'(swap), 32'd1);
    check("d25_big", 32'(man_big), 32'h4000000);
    check("d25_small", 32'(man_small), 32'h0000002);
    check("d25_exp", 32'(exp_out), 32'h98);
    pop();

    // Same vector on the STEP = 4 instance
    check("s4_ready", 32'(in_ready4), 32'd1);
    num1 = 32'h3F800000; num2 = 32'h4C000000; sel = 1'b0; in_valid4 = 1'b1;
    tick();
    edges = 1;
    in_valid4 = 1'b0;
    while (!out_valid4 && edges < 100) begin
      tick();
      edges++;
    end
    check("s4_lat", 32'(edges), 32'd8);
    check("s4_swap", 32'(swap4), 32'd1);
    check("s4_small", 32'(man_small4), 32'h0000002);
    check("s4_big", 32'(man_big4), 32'h4000000);
    check("s4_exp", 32'(exp_out4), 32'h98);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check("s4_pop", 32'(out_valid4), 32'd0);

    // d = 33 clamps to 27: only sticky survives
    run_op(32'h3F800001, 32'h50000000, 1'b0, edges);
    check("clamp_lat", 32'(edges), 32'd28);
    check("clamp_small", 32'(man_small), 32'h0000001);
    check("clamp_exp", 32'(exp_out), 32'hA0);
    check("clamp_swap", 32'(swap), 32'd1);
    pop();

    // d = 5 with set bits shifted out; negative num1 makes add effective-subtract
    run_op(32'hC2000000, 32'h3F800003, 1'b0, edges);
    check("stk_lat", 32'(edges), 32'd6);
    check("stk_small", 32'(man_small), 32'h0200001);
    check("stk_exp", 32'(exp_out), 32'h84);
    check("stk_effsub", 32'(eff_sub), 32'd1);
    check("stk_swap", 32'(swap), 32'd0);
    pop();

    // Denormal vs smallest normal: effective exponents match
    run_op(32'h00000001, 32'h00800000, 1'b0, edges);
    check("dn_lat", 32'(edges), 32'd1);
    check("dn_swap", 32'(swap), 32'd1);
    check("dn_big", 32'(man_big), 32'h4000000);
    check("dn_small", 32'(man_small), 32'h0000008);
    check("dn_exp", 32'(exp_out), 32'h01);
    pop();

    // Backpressure in DONE while inputs churn
    run_op(32'h40400000, 32'h40000000, 1'b0, edges);
    check("bp_lat", 32'(edges), 32'd1);
    for (int i = 0; i < 5; i++) begin
      num1 = $urandom; num2 = $urandom; sel = ~sel; in_valid = 1'b1;
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_big", 32'(man_big), 32'h6000000);
      check("bp_small", 32'(man_small), 32'h4000000);
      check("bp_exp", 32'(exp_out), 32'h80);
    end
    num1 = 32'h3F800000; num2 = 32'h3F800000;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_pop_valid", 32'(out_valid), 32'd0);
    check("bp_pop_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_no_accept", 32'(out_valid), 32'd0);
    check("bp_idle_ready", 32'(in_ready), 32'd1);

    // Reset in the middle of SHIFT
    num1 = 32'h3F800000; num2 = 32'h4C000000; sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_busy", 32'(in_ready), 32'd0);
    rstn = 1'b1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_small", 32'(man_small), 32'd0);
    check("mid_rst_big", 32'(man_big), 32'd0);
    check("mid_rst_exp", 32'(exp_out), 32'd0);
    check("mid_rst_swap", 32'(swap), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    rstn = 1'b0;
    tick();
    check("mid_rel_ready", 32'(in_ready), 32'd1);

    // Infinity operand: passed through unshifted
    run_op(32'h7F800000, 32'h3F800000, 1'b0, edges);
    check("inf_lat", 32'(edges), 32'd1);
    check("inf_special", 32'(special), 32'd1);
    check("inf_big", 32'(man_big), 32'h4000000);
    check("inf_small", 32'(man_small), 32'h4000000);
    check("inf_exp", 32'(exp_out), 32'hFF);
    check("inf_swap", 32'(swap), 32'd0);
    pop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
